// File: rtl/pid_rate_scaler.sv
`default_nettype none
// ============================================================================
// Module      : pid_rate_scaler
// Description : Gated rate scaler for Electron/Muon/Pion match outputs with
//               first-hit capture (fine index + coarse time) over a
//               programmable counting window. Snapshots are exposed on the
//               shared local bus.
// Revision    : 1.0 - initial release
// ============================================================================
module pid_rate_scaler #(
    parameter logic [7:0]  BASE        = 8'h40,
    parameter logic [31:0] WIN_DEFAULT = 32'd50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Electron,
    input  logic        Muon,
    input  logic        Pion,
    input  logic [31:0] Result,
    input  logic [31:0] DataIn,
    input  logic [7:0]  Address,
    input  logic        Read,
    input  logic        Write,
    output logic [31:0] DataOut,
    output logic        WinDone,
    output logic        Busy
);

    localparam logic [7:0] ADDR_CTRL   = BASE;
    localparam logic [7:0] ADDR_WINLEN = BASE + 8'd1;
    localparam logic [7:0] ADDR_ECNT   = BASE + 8'd2;
    localparam logic [7:0] ADDR_MCNT   = BASE + 8'd3;
    localparam logic [7:0] ADDR_PCNT   = BASE + 8'd4;
    localparam logic [7:0] ADDR_STATUS = BASE + 8'd5;
    localparam logic [7:0] ADDR_FTIME  = BASE + 8'd6;
    localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    // control / configuration registers
    logic        ctrl_en;
    logic        ctrl_single;
    logic [31:0] winlen;

    // live window state
    logic [31:0] down_cnt;
    logic [31:0] elapsed;
    logic [31:0] e_live;
    logic [31:0] m_live;
    logic [31:0] p_live;
    logic        live_valid;
    logic [4:0]  live_idx;
    logic [31:0] live_time;

    // snapshot registers
    logic [31:0] ecnt;
    logic [31:0] mcnt;
    logic [31:0] pcnt;
    logic        done;
    logic        fh_valid;
    logic [4:0]  fh_idx;
    logic [31:0] ftime;

    // FSM strobes
    logic        load;
    logic        count;
    logic        latch;

    logic        wr_ctrl;
    logic        wr_winlen;
    logic        wr_status;
    logic [4:0]  low_idx;

    assign wr_ctrl   = Write && (Address == ADDR_CTRL);
    assign wr_winlen = Write && (Address == ADDR_WINLEN);
    assign wr_status = Write && (Address == ADDR_STATUS);

    assign Busy    = (state == RUN);
    assign WinDone = (state == LATCH);

    // Index of the lowest set bit of Result (earliest fine slice)
    always_comb begin
        low_idx = 5'd0;
        for (int k = 31; k >= 0; k--) begin
            if (Result[k]) begin
                low_idx = 5'(k);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and datapath strobes
    always_comb begin
        state_next = state;
        load       = 1'b0;
        count      = 1'b0;
        latch      = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_en && (winlen != 32'd0)) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (!ctrl_en) begin
                    // software abort: drop the window without a snapshot
                    state_next = IDLE;
                end else begin
                    count = 1'b1;
                    if (down_cnt == 32'd0) begin
                        state_next = LATCH;
                    end
                end
            end
            LATCH: begin
                latch = 1'b1;
                if (ctrl_en && !ctrl_single && (winlen != 32'd0)) begin
                    state_next = RUN;
                    load       = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // CTRL and WINLEN bus registers; single-shot clears en at window end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en     <= 1'b0;
            ctrl_single <= 1'b0;
            winlen      <= WIN_DEFAULT;
        end else begin
            if (wr_ctrl) begin
                ctrl_en     <= DataIn[0];
                ctrl_single <= DataIn[1];
            end
            if (latch && ctrl_single) begin
                ctrl_en <= 1'b0;
            end
            if (wr_winlen) begin
                winlen <= DataIn;
            end
        end
    end

    // Live counters, window down-counter and first-hit capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            down_cnt   <= 32'd0;
            elapsed    <= 32'd0;
            e_live     <= 32'd0;
            m_live     <= 32'd0;
            p_live     <= 32'd0;
            live_valid <= 1'b0;
            live_idx   <= 5'd0;
            live_time  <= 32'd0;
        end else if (load) begin
            down_cnt   <= winlen - 32'd1;
            elapsed    <= 32'd0;
            e_live     <= 32'd0;
            m_live     <= 32'd0;
            p_live     <= 32'd0;
            live_valid <= 1'b0;
            live_idx   <= 5'd0;
            live_time  <= 32'd0;
        end else if (count) begin
            if (down_cnt != 32'd0) begin
                down_cnt <= down_cnt - 32'd1;
            end
            elapsed <= elapsed + 32'd1;
            if (e_live != CNT_MAX) begin
                e_live <= e_live + {31'd0, Electron};
            end
            if (m_live != CNT_MAX) begin
                m_live <= m_live + {31'd0, Muon};
            end
            if (p_live != CNT_MAX) begin
                p_live <= p_live + {31'd0, Pion};
            end
            if ((Result != 32'd0) && !live_valid) begin
                live_valid <= 1'b1;
                live_idx   <= low_idx;
                live_time  <= elapsed;
            end
        end
    end

    // Window-end snapshot; LATCH takes priority over a STATUS clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ecnt     <= 32'd0;
            mcnt     <= 32'd0;
            pcnt     <= 32'd0;
            done     <= 1'b0;
            fh_valid <= 1'b0;
            fh_idx   <= 5'd0;
            ftime    <= 32'd0;
        end else if (latch) begin
            ecnt     <= e_live;
            mcnt     <= m_live;
            pcnt     <= p_live;
            done     <= 1'b1;
            fh_valid <= live_valid;
            fh_idx   <= live_idx;
            ftime    <= live_time;
        end else if (wr_status) begin
            done     <= 1'b0;
            fh_valid <= 1'b0;
        end
    end

    // Combinational read mux, zero when not selected so it can be OR-ed
    always_comb begin
        DataOut = 32'd0;
        if (Read) begin
            case (Address)
                ADDR_CTRL:   DataOut = {30'd0, ctrl_single, ctrl_en};
                ADDR_WINLEN: DataOut = winlen;
                ADDR_ECNT:   DataOut = ecnt;
                ADDR_MCNT:   DataOut = mcnt;
                ADDR_PCNT:   DataOut = pcnt;
                ADDR_STATUS: DataOut = {16'd0, fh_valid, 2'b00, fh_idx,
                                        6'd0, done, Busy};
                ADDR_FTIME:  DataOut = ftime;
                default:     DataOut = 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pid_rate_scaler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pid_rate_scaler
// Description : Self-checking bench for pid_rate_scaler: register table,
//               window table, first-hit, continuous mode, abort, WINLEN=0,
//               async reset and randomized windows against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pid_rate_scaler;

    localparam logic [7:0] BASE = 8'h40;

    logic        clk = 1'b0;
    logic        rst;
    logic        Electron, Muon, Pion;
    logic [31:0] Result, DataIn;
    logic [7:0]  Address;
    logic        Read, Write;
    logic [31:0] DataOut;
    logic        WinDone, Busy;

    int total = 0;
    int bad   = 0;
    int wd_pulses = 0;

    pid_rate_scaler #(.BASE(BASE), .WIN_DEFAULT(32'd50000000)) dut (
        .clk(clk), .rst(rst), .Electron(Electron), .Muon(Muon), .Pion(Pion),
        .Result(Result), .DataIn(DataIn), .Address(Address), .Read(Read),
        .Write(Write), .DataOut(DataOut), .WinDone(WinDone), .Busy(Busy)
    );

    always #10 clk = ~clk;

    // count WinDone pulses, sampled mid-cycle
    always @(negedge clk) if (WinDone) wd_pulses++;

    typedef struct {
        logic [7:0]  off;
        logic        rd;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct {
        int          len;
        logic [15:0] em, mm, pm;
        logic [31:0] ee, me, pe;
    } win_vec_t;

    reg_vec_t    reset_tab [9];
    win_vec_t    win_tab [3];
    logic [31:0] res [16];
    logic [31:0] d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] val);
        Address = BASE + off;
        DataIn  = val;
        Write   = 1'b1;
        tick();
        Write   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] off, output logic [31:0] val);
        Address = BASE + off;
        Read    = 1'b1;
        #0.5;
        val     = DataOut;
        Read    = 1'b0;
        #0.1;
    endtask

    task automatic check_reset_regs(input string tag);
        for (int i = 0; i < 9; i++) begin
            Address = BASE + reset_tab[i].off;
            Read    = reset_tab[i].rd;
            #0.5;
            check($sformatf("%s_reg%0d", tag, i), DataOut, reset_tab[i].exp);
            Read = 1'b0;
        end
    endtask

    // Run one single-shot window of length len with per-cycle input masks
    // and Result values, then compare the snapshots to expectations. The
    // first-hit expectation is derived here from the Result list.
    task automatic run_single(input string tag, input int len,
                              input logic [15:0] em, input logic [15:0] mm,
                              input logic [15:0] pm, input logic [31:0] rv [16],
                              input logic [31:0] ee, input logic [31:0] me,
                              input logic [31:0] pe);
        int          p0;
        logic [31:0] v;
        logic        hit;
        int          hit_t;
        int          hit_i;
        hit = 1'b0; hit_t = 0; hit_i = 0;
        for (int c = 0; c < len; c++) begin
            if (!hit && rv[c] != 32'd0) begin
                hit = 1'b1;
                hit_t = c;
                for (int b = 31; b >= 0; b--) if (rv[c][b]) hit_i = b;
            end
        end
        wr(8'd1, len);
        wr(8'd0, 32'd3);
        p0 = wd_pulses;
        check({tag, "_idle_busy"}, {31'd0, Busy}, 32'd0);
        tick();
        check({tag, "_run_busy"}, {31'd0, Busy}, 32'd1);
        for (int c = 0; c < len; c++) begin
            Electron = em[c]; Muon = mm[c]; Pion = pm[c]; Result = rv[c];
            tick();
        end
        check({tag, "_windone"}, {31'd0, WinDone}, 32'd1);
        // dead LATCH cycle: these must not be counted or captured
        Electron = 1'b1; Muon = 1'b1; Pion = 1'b1; Result = 32'h8000_0000;
        tick();
        Electron = 1'b0; Muon = 1'b0; Pion = 1'b0; Result = 32'd0;
        check({tag, "_windone_low"}, {31'd0, WinDone}, 32'd0);
        check({tag, "_busy_after"}, {31'd0, Busy}, 32'd0);
        rd(8'd2, v); check({tag, "_ecnt"}, v, ee);
        rd(8'd3, v); check({tag, "_mcnt"}, v, me);
        rd(8'd4, v); check({tag, "_pcnt"}, v, pe);
        rd(8'd0, v); check({tag, "_ctrl"}, v, 32'd2);
        rd(8'd5, v);
        if (hit) begin
            check({tag, "_status"}, v, 32'h8002 | (32'(hit_i) << 8));
            rd(8'd6, v); check({tag, "_ftime"}, v, 32'(hit_t));
        end else begin
            check({tag, "_status"}, v & 32'h8003, 32'h2);
        end
        tick();
        check({tag, "_pulses"}, wd_pulses - p0, 32'd1);
    endtask

    initial begin
        reset_tab[0] = '{8'd0, 1'b1, 32'd0};
        reset_tab[1] = '{8'd1, 1'b1, 32'd50000000};
        reset_tab[2] = '{8'd2, 1'b1, 32'd0};
        reset_tab[3] = '{8'd3, 1'b1, 32'd0};
        reset_tab[4] = '{8'd4, 1'b1, 32'd0};
        reset_tab[5] = '{8'd5, 1'b1, 32'd0};
        reset_tab[6] = '{8'd6, 1'b1, 32'd0};
        reset_tab[7] = '{8'd7, 1'b1, 32'd0};       // out of range
        reset_tab[8] = '{8'd1, 1'b0, 32'd0};       // Read low

        win_tab[0] = '{4, 16'h000F, 16'h0003, 16'h0000, 32'd4, 32'd2, 32'd0};
        win_tab[1] = '{6, 16'h002A, 16'h003F, 16'h0001, 32'd3, 32'd6, 32'd1};
        win_tab[2] = '{1, 16'h0001, 16'h0000, 16'h0001, 32'd1, 32'd0, 32'd1};

        rst = 1'b1; Electron = 0; Muon = 0; Pion = 0; Result = 0;
        DataIn = 0; Address = 0; Read = 0; Write = 0;
        repeat (2) tick();
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_windone", {31'd0, WinDone}, 32'd0);
        rst = 1'b0;
        tick();
        check_reset_regs("reset");

        // table-driven windows
        for (int i = 0; i < 16; i++) res[i] = 32'd0;
        for (int w = 0; w < 3; w++) begin
            run_single($sformatf("win%0d", w), win_tab[w].len, win_tab[w].em,
                       win_tab[w].mm, win_tab[w].pm, res,
                       win_tab[w].ee, win_tab[w].me, win_tab[w].pe);
        end

        // first hit: index 16 at elapsed 3, later hit ignored
        for (int i = 0; i < 16; i++) res[i] = 32'd0;
        res[3] = 32'h0005_0000;
        res[4] = 32'h0000_0001;
        run_single("fhit", 10, 16'h0, 16'h0, 16'h0, res, 32'd0, 32'd0, 32'd0);
        rd(8'd5, d); check("fhit_status_hand", d, 32'h0000_9002);
        rd(8'd6, d); check("fhit_ftime_hand", d, 32'd3);

        // randomized single-shot windows against the model
        for (int n = 0; n < 10; n++) begin
            int          len;
            logic [15:0] em, mm, pm, lm;
            len = $urandom_range(1, 12);
            em = 16'($urandom); mm = 16'($urandom); pm = 16'($urandom);
            for (int i = 0; i < 16; i++)
                res[i] = ($urandom_range(0, 2) == 0) ? $urandom : 32'd0;
            lm = 16'((17'd1 << len) - 17'd1);
            run_single($sformatf("rnd%0d", n), len, em, mm, pm, res,
                       32'($countones(em & lm)), 32'($countones(mm & lm)),
                       32'($countones(pm & lm)));
        end

        // continuous mode: period L+1, LATCH-cycle hit dropped
        begin
            int p0;
            wr(8'd1, 32'd3);
            wr(8'd0, 32'd1);
            Electron = 1'b1;
            p0 = wd_pulses;
            tick();
            for (int k = 0; k < 3; k++) begin
                repeat (3) tick();
                check($sformatf("cont_windone%0d", k), {31'd0, WinDone}, 32'd1);
                tick();
                check($sformatf("cont_gap%0d", k), {31'd0, WinDone}, 32'd0);
                rd(8'd2, d); check($sformatf("cont_ecnt%0d", k), d, 32'd3);
            end
            wr(8'd0, 32'd0);
            tick();
            Electron = 1'b0;
            check("cont_stop_busy", {31'd0, Busy}, 32'd0);
            check("cont_pulses", wd_pulses - p0, 32'd3);
        end

        // abort mid-window after two counted hits
        begin
            int p0;
            p0 = wd_pulses;
            wr(8'd1, 32'd10);
            wr(8'd0, 32'd1);
            tick();
            Electron = 1'b1;
            repeat (2) tick();
            Electron = 1'b0;
            check("abort_busy_run", {31'd0, Busy}, 32'd1);
            wr(8'd0, 32'd0);
            tick();
            check("abort_busy", {31'd0, Busy}, 32'd0);
            repeat (15) tick();
            check("abort_pulses", wd_pulses - p0, 32'd0);
            rd(8'd2, d); check("abort_ecnt", d, 32'd3);
            rd(8'd5, d); check("abort_done", d & 32'h3, 32'h2);
        end

        // WINLEN=0: never leaves IDLE, done stays clear
        wr(8'd5, 32'd0);
        rd(8'd5, d); check("status_clear", d, 32'd0);
        wr(8'd1, 32'd0);
        wr(8'd0, 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("wl0_busy%0d", k), {31'd0, Busy}, 32'd0);
        end
        rd(8'd5, d); check("wl0_done", d, 32'd0);
        wr(8'd0, 32'd0);

        // asynchronous reset in the middle of a window
        wr(8'd1, 32'd20);
        wr(8'd0, 32'd1);
        tick();
        Electron = 1'b1;
        repeat (5) tick();
        check("arst_busy_before", {31'd0, Busy}, 32'd1);
        #4;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, Busy}, 32'd0);
        check("arst_windone", {31'd0, WinDone}, 32'd0);
        check_reset_regs("arst");
        Electron = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check_reset_regs("arst_post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pid_rate_scaler.md
# pid_rate_scaler

Gated rate scaler and first-hit capture sitting directly downstream of the per-channel fine-time/PID discriminator. Each 50 MHz cycle it counts the registered Electron, Muon and Pion match outputs and watches the 32-bit decoded leading-edge vector (`Result`) over a programmable counting window. At window end it snapshots the counts and the first hit's fine-time index and coarse time into local-bus registers. Slow-control software reads them through the same local bus used by the channel configuration registers.

## Interface
Parameters:
- `BASE`, 8'h40: local-bus base address; the block decodes `BASE+0` … `BASE+6`.
- `WIN_DEFAULT`, 32'd50000000: window length loaded at reset (1 s at 50 MHz).

Ports:
- `clk`  in  1  50 MHz system clock (same clock as the discriminator's `clk[2]`); all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `Electron`  in  1  electron match, registered in `clk` domain.
- `Muon`  in  1  muon match, registered in `clk` domain.
- `Pion`  in  1  pion match, registered in `clk` domain.
- `Result`  in  32  decoded leading-edge vector; bit k set = edge in fine slice k.
- `DataIn`  in  32  local-bus write data.
- `Address`  in  8  local-bus address.
- `Read`  in  1  local-bus read strobe.
- `Write`  in  1  local-bus write strobe, sampled on `clk`.
- `DataOut`  out  32  local-bus read data; 0 unless `Read` is high and the address is in range.
- `WinDone`  out  1  one-cycle pulse when a window closes.
- `Busy`  out  1  high while the FSM is in RUN.

## Operation
Registers (offsets from `BASE`):
- +0 CTRL, R/W: bit0 `en`, bit1 `single`; other bits read 0.
- +1 WINLEN, R/W: window length in cycles.
- +2 ECNT, RO: electron count snapshot.
- +3 MCNT, RO: muon count snapshot.
- +4 PCNT, RO: pion count snapshot.
- +5 STATUS: bit0 `Busy`, bit1 `done`, bits[12:8] first-hit index, bit15 first-hit valid. Any write clears `done` and first-hit valid.
- +6 FTIME, RO: coarse time of first hit = cycles elapsed since window start (0-based).

Read path: `DataOut` is combinational from `Address`/`Read`, OR-combinable with other bus slaves. Writes to RO offsets are ignored.

FSM: IDLE, RUN, LATCH.
- IDLE: `Busy`=0. If `en`=1 and WINLEN≠0, go to RUN. On entry: load the down-counter with WINLEN−1, clear the live counters, clear the elapsed counter, clear the live first-hit flag. If WINLEN=0, stay in IDLE and never assert `done`.
- RUN: `Busy`=1. Each cycle:
  - Each live counter adds its input bit; counters saturate at 32'hFFFFFFFF.
  - Elapsed counter increments.
  - If `Result`≠0 and the live first-hit flag is clear: capture the index of the lowest set bit (5 bits) and the elapsed count, then set the flag.
  - The down-counter decrements. When it reaches 0, that cycle's inputs are still counted, then go to LATCH.
  - If `en` is cleared by a bus write, return to IDLE next cycle. No snapshot is taken and `done` is unchanged.
- LATCH (1 cycle):
  - Copy the live counters to ECNT/MCNT/PCNT.
  - Copy the live first-hit index/valid/time to STATUS/FTIME.
  - Set `done` and pulse `WinDone`.
  - Inputs in this cycle are not counted (one dead cycle per window).
  - Next state: RUN with reload if `en`=1 and `single`=0. Otherwise IDLE; when `single`=1, `en` is cleared by hardware.
- WINLEN writes during RUN take effect at the next reload.
- A STATUS write coinciding with LATCH: LATCH wins, so `done`=1.

## Timing
- Reset: CTRL=0, WINLEN=`WIN_DEFAULT`, all snapshots/STATUS/FTIME=0, live counters 0, FSM=IDLE, `WinDone`=0, `Busy`=0, `DataOut`=0.
- Writing CTRL `en`=1 at edge N: RUN is entered at edge N+1, and `Busy` is high from N+1.
- With WINLEN=L, RUN lasts exactly L cycles, followed by one LATCH cycle. `WinDone` is high during the LATCH cycle. Snapshots are readable from the edge ending LATCH onward.
- Continuous mode period = L+1 cycles.
- Reset asserted mid-window: everything returns to reset values immediately; no snapshot is taken.

## Test plan
- Reset, then read all offsets → WINLEN=50000000; every other register 0; `Busy`=0.
- WINLEN=4, CTRL=3 (single); Electron high 4 cycles, Muon high 2, Pion 0 → ECNT=4, MCNT=2, PCNT=0. `WinDone` pulses once, `done`=1, then `en` reads 0 and the FSM is in IDLE.
- WINLEN=10, single; in RUN, `Result`=32'h0 for 3 cycles, then 32'h00050000, then 32'h00000001 → first-hit index=16, valid=1, FTIME=3.
- WINLEN=3, CTRL=1 (continuous), Electron held high → every 4 cycles `WinDone` pulses and ECNT=3, since the LATCH-cycle hit is dropped.
- Clear `en` mid-window after 2 counted hits → IDLE next cycle, ECNT keeps its previous value, no `WinDone`. Also WINLEN=0 with `en`=1 → stays IDLE, `done` stays 0.
- Async `rst` pulse during RUN with nonzero live counts → `Busy` drops without waiting for a clock edge, and all registers read reset values.
